// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default generator width, stuck timeout, capture FSM
// states and the code-to-high-width mapping used by generator and receiver.
package pwm_pkg;

  localparam int CBITS       = 17;
  localparam int TIMEOUT_CYC = (1 << CBITS) + 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // High width {0, code, 1, (cbits-5)'d0}, returned zero-extended to 32 bits.
  function automatic logic [31:0] code_to_width(input logic [2:0] code,
                                                input int cbits = CBITS);
    return {28'd0, code, 1'b1} << (cbits - 5);
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement bundle from the PWM capture block to its consumer.
// meas_valid is a one-cycle strobe with no backpressure (no ready); the data
// fields change only in the strobe cycle and hold until the next strobe.
interface pwm_capture_if #(
  parameter int CNT_W = pwm_pkg::CBITS + 1
);
  logic               meas_valid;
  logic [CNT_W-1:0]   high_len;
  logic [CNT_W-1:0]   period_len;
  logic [2:0]         duty_code;
  logic               code_exact;
  logic               stuck_high;
  logic               stuck_low;
  pwm_pkg::state_t    dbg_state;

  modport master (
    output meas_valid, high_len, period_len, duty_code, code_exact,
           stuck_high, stuck_low, dbg_state
  );

  modport slave (
    input meas_valid, high_len, period_len, duty_code, code_exact,
          stuck_high, stuck_low, dbg_state
  );
endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM line plus rise/fall detect
// on the synchronized level.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s2_d;
  assign fall  = ~s2 & s2_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period between rising edges, recovers
// the generator duty code and flags lines stuck high or low.
module pwm_capture #(
  parameter int CBITS       = pwm_pkg::CBITS,
  parameter int TIMEOUT_CYC = pwm_pkg::TIMEOUT_CYC,
  parameter int CNT_W       = CBITS + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pwm_in,
  pwm_capture_if.master  m
);
  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

  logic s2, rise, fall;

  pwm_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pwm_in),
    .level (s2),
    .rise  (rise),
    .fall  (fall)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             stuck_high_q, stuck_high_d;
  logic             stuck_low_q, stuck_low_d;
  logic             strobe;

  logic             meas_valid_q;
  logic [CNT_W-1:0] high_len_q, period_len_q;
  logic [2:0]       duty_q;
  logic             exact_q;

  // cnt_q lags the cycle count by one, so lengths are latched as cnt_q + 1
  // to include the edge cycle itself.
  always_comb begin
    state_d      = state_q;
    high_d       = high_q;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;
    strobe       = 1'b0;

    if (rise)              cnt_d = '0;
    else if (cnt_q == TMO) cnt_d = cnt_q;
    else                   cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
        end else if (cnt_q == TMO) begin
          if (s2) stuck_high_d = 1'b1;
          else    stuck_low_d  = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          high_d  = cnt_q + 1'b1;
        end else if (cnt_q == TMO) begin
          stuck_high_d = 1'b1;
          state_d      = IDLE;
        end
      end
      LOW: begin
        if (rise) begin
          state_d      = HIGH;
          strobe       = 1'b1;
          stuck_high_d = 1'b0;
          stuck_low_d  = 1'b0;
        end else if (cnt_q == TMO) begin
          stuck_low_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      high_q       <= '0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
      meas_valid_q <= 1'b0;
      high_len_q   <= '0;
      period_len_q <= '0;
      duty_q       <= '0;
      exact_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_q       <= high_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
      meas_valid_q <= strobe;
      if (strobe) begin
        high_len_q   <= high_q;
        period_len_q <= cnt_q + 1'b1;
        duty_q       <= high_q[CBITS-2:CBITS-4];
        exact_q      <= (high_q == CNT_W'(code_to_width(high_q[CBITS-2:CBITS-4], CBITS)));
      end
    end
  end

  assign m.meas_valid = meas_valid_q;
  assign m.high_len   = high_len_q;
  assign m.period_len = period_len_q;
  assign m.duty_code  = duty_q;
  assign m.code_exact = exact_q;
  assign m.stuck_high = stuck_high_q;
  assign m.stuck_low  = stuck_low_q;
  assign m.dbg_state  = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture at a reduced counter width; expected strobes come from
// edge timestamps of the driven waveform.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int CB  = 10;
  localparam int PER = 1 << CB;
  localparam int TMO = PER + 64;
  localparam int CW  = CB + 1;
  localparam int EW  = 32 + 2 * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm_in = 1'b0;

  pwm_capture_if #(.CNT_W(CW)) m ();

  pwm_capture #(.CBITS(CB), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .m      (m)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_strobes = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  bit armed = 1'b0;
  int last_high = 0, last_period = 0, last_duty = 0, last_exact = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_duty(input int h);
    return (h >> (CB - 4)) & 7;
  endfunction

  function automatic int exp_exact(input int h);
    return (h == ((2 * exp_duty(h) + 1) << (CB - 5))) ? 1 : 0;
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive(input bit lvl, input int n);
    if (lvl && !pwm_in) begin
      if (armed && (cyc - rise_cyc) < TMO)
        exp_q.push_back({32'(cyc + 3), CW'(fall_cyc - rise_cyc), CW'(cyc - rise_cyc)});
      armed    = 1'b1;
      rise_cyc = cyc;
    end else if (!lvl && pwm_in) begin
      fall_cyc = cyc;
    end
    pwm_in = lvl;
    repeat (n) @(negedge clk);
    if (lvl && n >= TMO) armed = 1'b0;
  endtask

  task automatic gen(input int code);
    int h;
    h = int'(code_to_width(3'(code), CB));
    drive(1'b1, h);
    drive(1'b0, PER - h);
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    armed = 1'b0;
    last_high = 0; last_period = 0; last_duty = 0; last_exact = 0;
    #1;
    check("rst_valid", 32'(m.meas_valid), 0);
    check("rst_high_len", 32'(m.high_len), 0);
    check("rst_period_len", 32'(m.period_len), 0);
    check("rst_duty", 32'(m.duty_code), 0);
    check("rst_exact", 32'(m.code_exact), 0);
    check("rst_stuck_high", 32'(m.stuck_high), 0);
    check("rst_stuck_low", 32'(m.stuck_low), 0);
    check("rst_state", 32'(m.dbg_state), 32'(IDLE));
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor: sampled 1 time unit after each posedge ----------------
  initial begin
    logic [EW-1:0] e;
    int due;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
        if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
          e = exp_q.pop_front();
          due = int'(e[EW-1 -: 32]);
          check("strobe_late", 32'(cyc), 32'(due));
        end
        if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
          e = exp_q.pop_front();
          last_high   = int'(e[2*CW-1 -: CW]);
          last_period = int'(e[CW-1:0]);
          last_duty   = exp_duty(last_high);
          last_exact  = exp_exact(last_high);
          n_strobes++;
          check("strobe_valid", 32'(m.meas_valid), 1);
          check("strobe_high_len", 32'(m.high_len), 32'(last_high));
          check("strobe_period_len", 32'(m.period_len), 32'(last_period));
          check("strobe_duty", 32'(m.duty_code), 32'(last_duty));
          check("strobe_exact", 32'(m.code_exact), 32'(last_exact));
          check("strobe_stuck_high", 32'(m.stuck_high), 0);
          check("strobe_stuck_low", 32'(m.stuck_low), 0);
        end else begin
          check("idle_valid", 32'(m.meas_valid), 0);
          check("hold_high_len", 32'(m.high_len), 32'(last_high));
          check("hold_period_len", 32'(m.period_len), 32'(last_period));
          check("hold_duty", 32'(m.duty_code), 32'(last_duty));
          check("hold_exact", 32'(m.code_exact), 32'(last_exact));
        end
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    int r;
    @(negedge clk);
    apply_reset();

    // generator code 5: three periods, first rise silent
    for (int i = 0; i < 3; i++) gen(5);
    check("code5_strobes", 32'(n_strobes), 2);
    check("code5_high_len", 32'(m.high_len), 352);
    check("code5_period_len", 32'(m.period_len), PER);
    check("code5_duty", 32'(m.duty_code), 5);
    check("code5_exact", 32'(m.code_exact), 1);

    for (int i = 0; i < 3; i++) gen(0);
    check("code0_high_len", 32'(m.high_len), 32);
    check("code0_duty", 32'(m.duty_code), 0);
    check("code0_exact", 32'(m.code_exact), 1);
    for (int i = 0; i < 3; i++) gen(7);
    check("code7_high_len", 32'(m.high_len), 480);
    check("code7_duty", 32'(m.duty_code), 7);
    check("code7_exact", 32'(m.code_exact), 1);

    // randomized mix of generator codes, arbitrary pulses and glitches
    for (int i = 0; i < 14; i++) begin
      r = int'($urandom_range(0, 2));
      if (r == 0) begin
        gen(int'($urandom_range(0, 7)));
      end else if (r == 1) begin
        drive(1'b1, int'($urandom_range(1, 60)));
        drive(1'b0, int'($urandom_range(1, 60)));
      end else begin
        drive(1'b1, 1);
        drive(1'b0, int'($urandom_range(3, 20)));
      end
    end

    // non-generator pulse, then a one-cycle glitch
    drive(1'b1, 50);
    drive(1'b0, 100);
    drive(1'b1, 50);
    check("nongen_high_len", 32'(m.high_len), 50);
    check("nongen_period_len", 32'(m.period_len), 150);
    check("nongen_duty", 32'(m.duty_code), 0);
    check("nongen_exact", 32'(m.code_exact), 0);
    drive(1'b0, 100);
    drive(1'b1, 1);
    drive(1'b0, 30);
    drive(1'b1, 10);
    check("glitch_high_len", 32'(m.high_len), 1);
    check("glitch_period_len", 32'(m.period_len), 31);

    // stuck high, then recovery on the second following rise
    drive(1'b0, 30);
    base = n_strobes;
    drive(1'b1, TMO + 112);
    check("stuckh_flag", 32'(m.stuck_high), 1);
    check("stuckh_low_flag", 32'(m.stuck_low), 0);
    check("stuckh_strobes", 32'(n_strobes - base), 1);
    drive(1'b0, 30);
    check("stuckh_sticky", 32'(m.stuck_high), 1);
    base = n_strobes;
    gen(3);
    check("stuckh_first_rise", 32'(m.stuck_high), 1);
    check("stuckh_no_strobe", 32'(n_strobes - base), 0);
    gen(3);
    check("stuckh_cleared", 32'(m.stuck_high), 0);
    check("stuckl_cleared", 32'(m.stuck_low), 0);
    check("stuckh_recover_strobe", 32'(n_strobes - base), 1);

    // reset in the middle of a high phase, then a low-stuck line
    drive(1'b1, 20);
    check("prereset_state", 32'(m.dbg_state), 32'(HIGH));
    apply_reset();
    repeat (TMO - 20) @(negedge clk);
    check("stuckl_early", 32'(m.stuck_low), 0);
    repeat (40) @(negedge clk);
    check("stuckl_flag", 32'(m.stuck_low), 1);
    check("stuckl_high_flag", 32'(m.stuck_high), 0);

    base = n_strobes;
    gen(2);
    check("post_reset_first_rise", 32'(n_strobes - base), 0);
    gen(2);
    gen(2);
    check("post_reset_strobes", 32'(n_strobes - base), 2);
    check("post_reset_high_len", 32'(m.high_len), 160);
    check("post_reset_stuck_low", 32'(m.stuck_low), 0);

    drive(1'b0, 10);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- PWM receiver/decoder: measures high time and period of an incoming PWM line and recovers the 3-bit duty code the PWM generator encodes as a high width of {0, code[2:0], 1, 12'd0} over a 2^CBITS period.
- Sits on the consumer side of a PWM link: board-level loopback check of the generator, or decoding an external PWM source.
- Flags lines stuck high or stuck low, so the "pulse eventually drops" liveness property is checked in hardware too.

Parameters:
- CBITS, 17, generator counter width; nominal period is 2^CBITS cycles.
- TIMEOUT_CYC, 132096 (2^CBITS + 1024), cycles without the expected edge before a stuck flag is set.
- CNT_W, CBITS+1, internal counter / measurement width; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pwm_in  in  1  asynchronous PWM input.
- meas_valid  out  1  one-cycle strobe; measurement outputs updated this cycle.
- high_len  out  CNT_W  cycles pwm was high in the last complete period.
- period_len  out  CNT_W  cycles between the last two rising edges.
- duty_code  out  3  high_len[CBITS-2:CBITS-4] (bits 15:13 at default).
- code_exact  out  1  high_len == {0, duty_code, 1, (CBITS-5)'d0}.
- stuck_high  out  1  sticky; line high for >= TIMEOUT_CYC.
- stuck_low  out  1  sticky; line low (or no edges) for >= TIMEOUT_CYC.

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0, synchronizer flops 0, cnt 0, state IDLE. Reset mid-period discards the partial measurement.
- Input sync: two flops, s1 -> s2. Edge detect on s2 vs s2_d: rise = s2 & ~s2_d, fall = ~s2 & s2_d.
- Counter cnt:
  - Cleared to 0 on the rise cycle; otherwise increments each cycle.
  - Saturates at TIMEOUT_CYC; never wraps.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: rise -> HIGH with cnt := 0. No output update. The first rise after reset or timeout never produces meas_valid.
  - HIGH: fall -> LOW and high_q := cnt, so a pulse sampled high for H cycles gives H. If cnt == TIMEOUT_CYC -> stuck_high := 1, go IDLE.
  - LOW: rise -> HIGH and cnt := 0. In the same cycle, register high_len := high_q, period_len := cnt, duty_code, code_exact, and meas_valid := 1. Also clear both stuck flags. If cnt == TIMEOUT_CYC -> stuck_low := 1, go IDLE.
  - IDLE with no rise: when cnt reaches TIMEOUT_CYC and s2 == 0 -> stuck_low := 1. When s2 == 1 -> stuck_high := 1. cnt holds at saturation; the flag is set once and stays set.
- Latency: meas_valid is high exactly 3 clk after pwm_in rises, counting from the first sampling clk (2 sync + 1 register).
- Outputs hold their values between strobes.
- Width rules:
  - duty_code is taken from high_len as registered.
  - A high_len of 2^(CBITS-1) or more cannot come from a valid generator code. In that case code_exact = 0, and duty_code is still the raw bits.
- One-cycle glitches (rise then fall on consecutive sync samples) are measured as high_len = 1; there is no filtering.
- Rise and fall cannot coincide on s2. A timeout in the same cycle as an edge: the edge wins, no flag.

Decomposition:
- Package pwm_pkg: CBITS default, TIMEOUT_CYC, the state enum (IDLE/HIGH/LOW), and function code_to_width(code) returning {0, code, 1, 12'd0}. The generator and this block share the function.
- One natural sub-module: pwm_sync_edge (2-flop synchronizer plus rise/fall detect, async active-low reset). The FSM and counters stay in the top.

Test Plan:
- Drive the PWM generator with sw = 4'b1010 (code 5) in loopback, run 3 periods -> 2 strobes, high_len = 45056, period_len = 131072, duty_code = 5, code_exact = 1, flags 0.
- Sweep codes 0 and 7 -> high_len 4096 /61440, duty_code 0 / 7, code_exact = 1. First strobe appears only at the second rising edge.
- Hold pwm_in = 1 for 140000 cycles after a rise -> stuck_high = 1 at cnt = 132096, no meas_valid. Resume PWM -> flag clears on the second subsequent rise, together with that strobe.
- Hold pwm_in = 0 after reset -> stuck_low = 1 after 132096 cycles; stuck_high stays 0.
- Non-generator input (high 1000, low 2000 cycles) -> high_len = 1000, period_len = 3000, duty_code = 0, code_exact = 0. A 1-cycle glitch period -> high_len = 1.
- Assert rst_n low mid-HIGH -> all outputs 0 immediately (async). After release, no strobe until two full rising edges have been seen.
